// File: rtl/auto_seq_pkg.sv
// Shared definitions for the auto-play sequencer: FSM state encoding, note
// length codes, score word field positions and the tempo clamp.
// Score word layout: {end_flag, len[1:0], note[NOTE_W-1:0]}.
package auto_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SOUND  = 3'd2,
    ST_GAP    = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Note length codes
  localparam logic [1:0] LEN_BEAT    = 2'b00;
  localparam logic [1:0] LEN_HALF    = 2'b01;
  localparam logic [1:0] LEN_QUARTER = 2'b10;
  localparam logic [1:0] LEN_DOUBLE  = 2'b11;

  localparam int unsigned LEN_W = 2;

  // Fastest supported tempo; code 11 falls back to this
  localparam logic [1:0] TEMPO_MAX = 2'b10;

  // Score word field positions, expressed against the note width
  function automatic int unsigned word_w(input int unsigned note_w);
    return note_w + LEN_W + 1;
  endfunction

  function automatic int unsigned len_lsb(input int unsigned note_w);
    return note_w;
  endfunction

  function automatic int unsigned end_bit(input int unsigned note_w);
    return note_w + LEN_W;
  endfunction

  function automatic logic [1:0] tempo_clamp(input logic [1:0] t);
    return (t > TEMPO_MAX) ? TEMPO_MAX : t;
  endfunction

  // Note duration in cycles from the beat length and the len code
  function automatic logic [31:0] note_cycles(input logic [31:0] beat,
                                              input logic [1:0]  len);
    logic [31:0] r;
    case (len)
      LEN_HALF:    r = beat >> 1;
      LEN_QUARTER: r = beat >> 2;
      LEN_DOUBLE:  r = beat << 1;
      default:     r = beat;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/auto_sequencer_song_rom.sv
// song_rom: fixed score storage with a registered (synchronous) read.
// Ports:
//   clk  - clock
//   song - song select
//   addr - score address within the song
//   word - score word {end_flag, len, note}, valid one cycle after addr/song
module song_rom
  import auto_seq_pkg::*;
#(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned SONG_W = 2,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                    clk,
  input  logic [SONG_W-1:0]       song,
  input  logic [ADDR_W-1:0]       addr,
  output logic [NOTE_W+LEN_W:0]   word
);

  localparam int unsigned WORD_W = word_w(NOTE_W);

  logic [WORD_W-1:0] rom_word;

  function automatic logic [WORD_W-1:0] mk(input logic e, input logic [1:0] len,
                                           input int unsigned n);
    return {e, len, NOTE_W'(n)};
  endfunction

  // Score table; unlisted locations read as end words
  always_comb begin
    rom_word = mk(1'b1, LEN_BEAT, 0);
    case (32'(song))
      32'd0: begin
        case (32'(addr))
          32'd0:   rom_word = mk(1'b0, LEN_BEAT, 8);
          32'd1:   rom_word = mk(1'b0, LEN_HALF, 12);
          default: ;
        endcase
      end
      32'd1: begin
        case (32'(addr))
          32'd0:   rom_word = mk(1'b0, LEN_QUARTER, 5);
          32'd1:   rom_word = mk(1'b0, LEN_HALF, 9);
          default: ;
        endcase
      end
      // song 2 is intentionally empty
      32'd3: begin
        case (32'(addr))
          32'd0:   rom_word = mk(1'b0, LEN_DOUBLE, 3);
          32'd1:   rom_word = mk(1'b0, LEN_QUARTER, 0);
          32'd2:   rom_word = mk(1'b0, LEN_QUARTER, 17);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    word <= rom_word;
  end

endmodule

// File: rtl/auto_sequencer.sv
// auto_sequencer: plays a stored score on a buzzer, one note per score word,
// with tempo scaling, pause, looping and song selection.
// Optional macro AUTO_SEQ_LED_EN: drive a one-hot key LED for the sounding note.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   enable            - auto-play mode active
//   song_sel          - song select
//   pause             - freeze playback while high
//   loop              - restart the song after its end marker
//   tempo             - beat length divided by 2^tempo (11 behaves as 10)
//   note, note_on     - buzzer note code and sounding flag
//   busy, done        - playing status, end-of-song pulse
//   led               - key indicator LEDs
module auto_sequencer
  import auto_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned NOTE_W   = 5,
  parameter int unsigned SONG_W   = 2,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned GAP_DEN  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              pause,
  input  logic              loop,
  input  logic [1:0]        tempo,
  output logic [NOTE_W-1:0] note,
  output logic              note_on,
  output logic              busy,
  output logic              done,
  output logic [7:0]        led
);

  localparam int unsigned WORD_W  = word_w(NOTE_W);
  localparam int unsigned LEN_LSB = len_lsb(NOTE_W);
  localparam int unsigned END_BIT = end_bit(NOTE_W);
  localparam int unsigned CNT_W   = $clog2(2 * CLK_FREQ + 1);

  state_t              state_q, state_d, saved_q, saved_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    snd_len_q, snd_len_d;
  logic [CNT_W-1:0]    gap_len_q, gap_len_d;
  logic [NOTE_W-1:0]   cur_note_q, cur_note_d;

  logic [WORD_W-1:0]   rom_word;
  logic                w_end;
  logic [1:0]          w_len;
  logic [NOTE_W-1:0]   w_note;
  logic [31:0]         beat_cyc, dur_cyc, gap_cyc, snd_cyc;
  logic                song_chg, run_state;

  logic [NOTE_W-1:0]   note_nx;
  logic                note_on_nx, busy_nx, done_nx;

  // ROM is addressed with next-cycle values so the word is ready in FETCH
  song_rom #(
    .NOTE_W (NOTE_W),
    .SONG_W (SONG_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .song (song_d),
    .addr (addr_d),
    .word (rom_word)
  );

  assign w_end  = rom_word[END_BIT];
  assign w_len  = rom_word[LEN_LSB +: LEN_W];
  assign w_note = rom_word[NOTE_W-1:0];

  // Note timing, sampled only in FETCH so tempo changes wait for the next note
  assign beat_cyc = 32'(CLK_FREQ) >> tempo_clamp(tempo);
  assign dur_cyc  = note_cycles(beat_cyc, w_len);
  assign gap_cyc  = dur_cyc / 32'(GAP_DEN);
  assign snd_cyc  = (dur_cyc == gap_cyc) ? 32'd1 : dur_cyc - gap_cyc;

  assign song_chg  = (song_sel != song_q);
  assign run_state = (state_q == ST_FETCH) || (state_q == ST_SOUND) ||
                     (state_q == ST_GAP)   || (state_q == ST_PAUSED);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      saved_q    <= ST_IDLE;
      song_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      snd_len_q  <= '0;
      gap_len_q  <= '0;
      cur_note_q <= '0;
      note       <= '0;
      note_on    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      song_q     <= song_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      snd_len_q  <= snd_len_d;
      gap_len_q  <= gap_len_d;
      cur_note_q <= cur_note_d;
      note       <= note_nx;
      note_on    <= note_on_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    song_d     = song_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    snd_len_d  = snd_len_q;
    gap_len_d  = gap_len_q;
    cur_note_d = cur_note_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          song_d  = song_sel;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (pause) begin
          saved_d = ST_FETCH;
          state_d = ST_PAUSED;
        end else if (w_end) begin
          // empty song never loops
          if (addr_q == '0 || !loop) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end else begin
          cur_note_d = w_note;
          snd_len_d  = CNT_W'(snd_cyc);
          gap_len_d  = CNT_W'(gap_cyc);
          cnt_d      = '0;
          state_d    = ST_SOUND;
        end
      end
      ST_SOUND: begin
        if (cnt_q == snd_len_q - CNT_W'(1)) begin
          cnt_d = '0;
          if (gap_len_q == '0) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == gap_len_q - CNT_W'(1)) begin
          cnt_d   = '0;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PAUSED: begin
        if (!pause) state_d = saved_q;
      end
      ST_DONE: begin
        if (song_chg) begin
          song_d  = song_sel;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The cycle in which pause is seen still counts toward the note
    if ((state_q == ST_SOUND || state_q == ST_GAP) && pause) begin
      saved_d = state_d;
      state_d = ST_PAUSED;
    end

    // New song while playing restarts from the top of that song
    if (run_state && song_chg) begin
      song_d = song_sel;
      addr_d = '0;
      cnt_d  = '0;
      if (pause) begin
        saved_d = ST_FETCH;
        state_d = ST_PAUSED;
      end else begin
        state_d = ST_FETCH;
      end
    end

    if (!enable) state_d = ST_IDLE;
  end

  // Output decode from the next state, registered alongside it
  always_comb begin
    note_nx    = '0;
    note_on_nx = 1'b0;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    if (state_d == ST_SOUND) begin
      note_nx    = cur_note_d;
      note_on_nx = (cur_note_d != '0);
    end
    busy_nx = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_nx = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

`ifdef AUTO_SEQ_LED_EN
  logic [2:0] led_idx;
  logic [7:0] led_nx;

  // Key LED: one-hot of (note-1) mod 8 while a real note sounds
  always_comb begin
    led_idx = 3'(cur_note_d - NOTE_W'(1));
    led_nx  = 8'd0;
    if (state_d == ST_SOUND && cur_note_d != '0) led_nx = 8'd1 << led_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= 8'd0;
    else     led <= led_nx;
  end
`else
  assign led = 8'd0;
`endif

endmodule

// File: tb/tb_auto_sequencer.sv
// Scoreboard bench for auto_sequencer: the stimulus pushes the expected stream
// of note runs (value, length in cycles while busy) and done pulses; a monitor
// run-length encodes the DUT output and pops/compares each completed event.
module tb_auto_sequencer;

  localparam int unsigned CLK_FREQ = 20;
  localparam int unsigned NOTE_W   = 5;
  localparam int unsigned SONG_W   = 2;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned GAP_DEN  = 10;

  logic              clk, rst, enable, pause, loop;
  logic [SONG_W-1:0] song_sel;
  logic [1:0]        tempo;
  logic [NOTE_W-1:0] note;
  logic              note_on, busy, done;
  logic [7:0]        led;

  typedef struct {
    bit is_done;
    int nval;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  ev_idx  = 0;

  auto_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .NOTE_W   (NOTE_W),
    .SONG_W   (SONG_W),
    .ADDR_W   (ADDR_W),
    .GAP_DEN  (GAP_DEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .song_sel (song_sel),
    .pause    (pause),
    .loop     (loop),
    .tempo    (tempo),
    .note     (note),
    .note_on  (note_on),
    .busy     (busy),
    .done     (done),
    .led      (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic exp_run(input int n, input int l);
    ev_t e;
    e.is_done = 1'b0;
    e.nval    = n;
    e.len     = l;
    exp_q.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e.is_done = 1'b1;
    e.nval    = 0;
    e.len     = 0;
    exp_q.push_back(e);
  endtask

  task automatic emit(input bit d, input int n, input int l);
    ev_t e;
    n_tests++;
    ev_idx++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event%0d: got done=%0d note=%0d len=%0d, required no event", ev_idx, d, n, l);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != d || e.nval != n || e.len != l) begin
        n_fail++;
        $display("FAIL event%0d: got done=%0d note=%0d len=%0d, required done=%0d note=%0d len=%0d",
                 ev_idx, d, n, l, e.is_done, e.nval, e.len);
      end
    end
  endtask

  // Monitor: run-length encode note while busy, report done pulses
  initial begin : monitor
    bit         run_active;
    int         run_note;
    int         run_len;
    logic [7:0] exp_led;
    int         idx;
    run_active = 1'b0;
    run_note   = 0;
    run_len    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_active = 1'b0;
      end else begin
        check("note_on", int'(note_on), (note != '0) ? 1 : 0);
        exp_led = 8'd0;
`ifdef AUTO_SEQ_LED_EN
        if (note != '0) begin
          idx     = (int'(note) - 1) % 8;
          exp_led = 8'd1 << idx;
        end
`else
        idx = 0;
`endif
        check("led", int'(led), int'(exp_led));
        if (busy) begin
          if (run_active && int'(note) == run_note) begin
            run_len++;
          end else begin
            if (run_active) emit(1'b0, run_note, run_len);
            run_note   = int'(note);
            run_len    = 1;
            run_active = 1'b1;
          end
        end else if (run_active) begin
          emit(1'b0, run_note, run_len);
          run_active = 1'b0;
        end
        if (done) emit(1'b1, 0, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_done: got no done pulse within %0d cycles, required a pulse", budget);
    end
  endtask

  task automatic stop_play();
    enable = 1'b0;
    tick(2);
  endtask

  initial begin : stimulus
    rst      = 1'b1;
    enable   = 1'b0;
    pause    = 1'b0;
    loop     = 1'b0;
    tempo    = 2'b00;
    song_sel = '0;
    tick(3);
    check("rst_note",    int'(note),    0);
    check("rst_note_on", int'(note_on), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_done",    int'(done),    0);
    check("rst_led",     int'(led),     0);
    rst = 1'b0;
    tick(2);

    // Song 0 plain: 8 for 18, gap 2 + fetch, 12 for 9, gap 1 + end fetch
    exp_run(0, 1); exp_run(8, 18); exp_run(0, 3); exp_run(12, 9); exp_run(0, 2); exp_done();
    song_sel = 2'd0;
    enable   = 1'b1;
    wait_done(200);
    stop_play();

    // Song 0 looping once, then loop released during the second pass
    exp_run(0, 1); exp_run(8, 18); exp_run(0, 3); exp_run(12, 9); exp_run(0, 3);
    exp_run(8, 18); exp_run(0, 3); exp_run(12, 9); exp_run(0, 2); exp_done();
    loop   = 1'b1;
    enable = 1'b1;
    tick(45);
    loop = 1'b0;
    wait_done(200);
    stop_play();

    // Pause after 5 sounding cycles, held 7 cycles
    exp_run(0, 1); exp_run(8, 5); exp_run(0, 7); exp_run(8, 13); exp_run(0, 3);
    exp_run(12, 9); exp_run(0, 2); exp_done();
    enable = 1'b1;
    tick(6);
    pause = 1'b1;
    tick(7);
    pause = 1'b0;
    wait_done(200);

    stop_play();

    // Song change 0->1 mid-note, then from DONE to the empty song 2
    exp_run(0, 1); exp_run(8, 5); exp_run(0, 1); exp_run(5, 5); exp_run(0, 1);
    exp_run(9, 9); exp_run(0, 2); exp_done();
    exp_run(0, 1); exp_done();
    song_sel = 2'd0;
    enable   = 1'b1;
    tick(6);
    song_sel = 2'd1;
    wait_done(200);
    song_sel = 2'd2;
    tick(1);
    wait_done(20);
    stop_play();

    // Song 3: double-length note, quarter rest, quarter note with no gap
    exp_run(0, 1); exp_run(3, 36); exp_run(0, 11); exp_run(17, 5); exp_run(0, 1); exp_done();
    song_sel = 2'd3;
    enable   = 1'b1;
    wait_done(200);
    stop_play();

    // Tempo 11 clamps to 10: beat of 5 cycles, no gaps
    exp_run(0, 1); exp_run(8, 5); exp_run(0, 1); exp_run(12, 2); exp_run(0, 1); exp_done();
    song_sel = 2'd0;
    tempo    = 2'b11;
    enable   = 1'b1;
    wait_done(200);
    stop_play();

    // Tempo change mid-note applies only from the next fetch
    exp_run(0, 1); exp_run(8, 18); exp_run(0, 3); exp_run(12, 5); exp_run(0, 1); exp_done();
    tempo  = 2'b00;
    enable = 1'b1;
    tick(5);
    tempo = 2'b01;
    wait_done(200);
    stop_play();
    tempo = 2'b00;

    // Asynchronous reset in the middle of a gap
    exp_run(0, 1); exp_run(8, 18);
    enable = 1'b1;
    tick(21);
    check("gap_busy", int'(busy), 1);
    check("gap_note", int'(note), 0);
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check("arst_note",    int'(note),    0);
    check("arst_note_on", int'(note_on), 0);
    check("arst_busy",    int'(busy),    0);
    check("arst_done",    int'(done),    0);
    check("arst_led",     int'(led),     0);
    tick(2);
    rst = 1'b0;
    tick(3);

    check("events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
